iob_eth_crc_multi: RTL and testbench

Parametrised IEEE 802.3 CRC-32 engine that consumes 1, 2, 4 or 8 bytes per clock with partial last-beat byte enables and a valid/ready handshake. It tracks frame boundaries, produces the wire-order FCS for the TX path, and optionally checks the residue for the RX path. It sits between the MAC byte/word datapath and the frame-framing logic, one instance per direction.

---
 rtl/iob_eth_crc_multi.sv | 130 +++++++++++++
 tb/tb_iob_eth_crc_multi.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_crc_multi.sv
// iob_eth_crc_multi: IEEE 802.3 CRC-32 over 1/2/4/8-byte beats with partial last-beat byte enables.
// Latency: crc_o/fcs_o follow an accepted beat by one cycle; done_o pulses the cycle after the last beat.
// Backpressure: ready_o is low only in reset, while start_i is high, and in the one-cycle DONE state.
// Optional RX residue checker is built when the macro IOB_ETH_CRC_CHECK_EN is defined.
module iob_eth_crc_multi #(
   parameter  int DATA_W = 8,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic              last_i,
   output logic [31:0]       crc_o,
   output logic [31:0]       fcs_o,
   output logic              done_o,
   output logic              crc_ok_o,
   output logic              busy_o
);

   localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC_SEED = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] crc_q;
   logic [31:0] crc_d;
   logic        accept;

   // One byte through the non-reflected register, data bit 0 entering first.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] dat);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         fb = c[31] ^ dat[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      end
      return c;
   endfunction

   function automatic logic [7:0] bitrev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

   // start_i wins over a presented beat, so the beat must not look accepted.
   assign ready_o  = ~rst & ~start_i & (state_q != ST_DONE);
   assign accept   = valid_i & ready_o;
   assign done_o   = (state_q == ST_DONE);
   assign busy_o   = (state_q == ST_RUN);
   assign crc_o    = crc_q;

   // Fold enabled lanes in wire order; the first beat of a frame always restarts from the seed.
   always_comb begin
      crc_d = (state_q == ST_IDLE) ? CRC_SEED : crc_q;
      for (int l = 0; l < BE_W; l++) begin
         if (be_i[l]) begin
            crc_d = crc_byte(crc_d, data_i[8*l +: 8]);
         end
      end
   end

   // FCS is pure rewiring plus inversion of the CRC register, so it carries the register's timing.
   always_comb begin
      fcs_o = '0;
      for (int k = 0; k < 4; k++) begin
         fcs_o[8*k +: 8] = ~bitrev8(crc_q[31-8*k -: 8]);
      end
   end

   // Frame FSM and CRC register; DONE lasts exactly one cycle and blocks input for that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         crc_q   <= CRC_SEED;
      end else if (start_i) begin
         state_q <= ST_IDLE;
         crc_q   <= CRC_SEED;
      end else begin
         case (state_q)
            ST_IDLE, ST_RUN: begin
               if (accept) begin
                  crc_q   <= crc_d;
                  state_q <= last_i ? ST_DONE : ST_RUN;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef IOB_ETH_CRC_CHECK_EN
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   logic crc_ok_q;

   // Residue verdict lands with done_o; any new first beat, abort or reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_ok_q <= 1'b0;
      end else if (start_i) begin
         crc_ok_q <= 1'b0;
      end else if (accept) begin
         crc_ok_q <= last_i & (crc_d == CRC_RESIDUE);
      end
   end

   assign crc_ok_o = crc_ok_q;
`else
   assign crc_ok_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_eth_crc_multi.sv
// Bench for iob_eth_crc_multi: one instance per legal DATA_W (8/16/32/64), directed frames,
// reference CRC computed with the reflected LSB-first algorithm (0xEDB88320).
module tb_iob_eth_crc_multi;

   logic        clk;
   logic        rst;
   logic [3:0]  start_s;
   logic [3:0]  valid_s;
   logic [3:0]  last_s;
   logic [3:0]  ready_s;
   logic [3:0]  done_s;
   logic [3:0]  ok_s;
   logic [3:0]  busy_s;
   logic [63:0] data_s [4];
   logic [7:0]  be_s   [4];
   logic [31:0] crc_s  [4];
   logic [31:0] fcs_s  [4];

   logic [7:0]  fb [$];
   int          checks = 0;
   int          errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DW = 8 << g;
      iob_eth_crc_multi #(.DATA_W(DW)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .start_i  (start_s[g]),
         .valid_i  (valid_s[g]),
         .ready_o  (ready_s[g]),
         .data_i   (data_s[g][DW-1:0]),
         .be_i     (be_s[g][DW/8-1:0]),
         .last_i   (last_s[g]),
         .crc_o    (crc_s[g]),
         .fcs_o    (fcs_s[g]),
         .done_o   (done_s[g]),
         .crc_ok_o (ok_s[g]),
         .busy_o   (busy_s[g])
      );
   end

   // Reflected CRC register (before final inversion) over fb[first .. first+n-1].
   // Expected fcs_o = ~value, expected crc_o = bit-reverse of value.
   function automatic logic [31:0] ref_crc(input int first, input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = first; i < first + n; i++) begin
         c = c ^ {24'h0, fb[i]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return c;
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = x[31-i];
      end
      return r;
   endfunction

   // Drive fb[0..n-1] into instance w; returns #1 after the negedge following last-beat acceptance.
   task automatic send_frame(input int w, input int n, input int gap_max, input bit empty_last);
      int bw;
      int nb;
      int pos;
      int gap;
      int cnt;
      bw  = 1 << w;
      nb  = (n + bw - 1) / bw;
      if (empty_last || nb == 0) nb++;
      pos = 0;
      for (int b = 0; b < nb; b++) begin
         gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         repeat (gap) begin
            @(negedge clk);
            valid_s[w] = 1'b0;
         end
         @(negedge clk);
         valid_s[w] = 1'b1;
         last_s[w]  = (b == nb - 1);
         be_s[w]    = '0;
         data_s[w]  = {$urandom, $urandom};
         for (int l = 0; l < bw; l++) begin
            if (pos < n) begin
               data_s[w][8*l +: 8] = fb[pos];
               be_s[w][l]          = 1'b1;
               pos++;
            end
         end
         #1;
         cnt = 0;
         while (!ready_s[w] && cnt < 100) begin
            @(negedge clk);
            #1;
            cnt++;
         end
         if (cnt >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout w=%0d ready=%b required=1", w, ready_s[w]);
         end
      end
      @(negedge clk);
      valid_s[w] = 1'b0;
      last_s[w]  = 1'b0;
      be_s[w]    = '0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      for (int w = 0; w < 4; w++) begin
         checks++;
         if (ready_s[w] !== 1'b0) begin errors++; $display("FAIL reset_ready w=%0d got %b expected 0", w, ready_s[w]); end
         checks++;
         if (crc_s[w] !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_crc w=%0d got %h expected ffffffff", w, crc_s[w]); end
         checks++;
         if (fcs_s[w] !== 32'h0) begin errors++; $display("FAIL reset_fcs w=%0d got %h expected 00000000", w, fcs_s[w]); end
         checks++;
         if ({done_s[w], busy_s[w], ok_s[w]} !== 3'b000) begin errors++; $display("FAIL reset_flags w=%0d got done/busy/ok=%b expected 000", w, {done_s[w], busy_s[w], ok_s[w]}); end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int w = 0; w < 4; w++) begin
         checks++;
         if (ready_s[w] !== 1'b1) begin errors++; $display("FAIL idle_ready w=%0d got %b expected 1", w, ready_s[w]); end
      end
   endtask

   task automatic test_byte8();
      string s = "123456789";
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      fb.delete();
      for (int i = 0; i < 9; i++) fb.push_back(s[i]);
      send_frame(0, 9, 0, 0);
      checks++;
      if (done_s[0] !== 1'b1) begin errors++; $display("FAIL b8_done got %b expected 1", done_s[0]); end
      checks++;
      if (fcs_s[0] !== 32'hCBF43926) begin errors++; $display("FAIL b8_fcs got %h expected cbf43926", fcs_s[0]); end
      // Non-reflected register holds the bit-reverse of ~0xCBF43926 (0x340BC6D9).
      checks++;
      if (crc_s[0] !== 32'h9B63D02C) begin errors++; $display("FAIL b8_crc got %h expected 9b63d02c", crc_s[0]); end
      @(negedge clk);
      #1;
      checks++;
      if (done_s[0] !== 1'b0) begin errors++; $display("FAIL b8_done_pulse got %b expected 0", done_s[0]); end
      checks++;
      if (fcs_s[0] !== 32'hCBF43926) begin errors++; $display("FAIL b8_fcs_hold got %h expected cbf43926", fcs_s[0]); end
   endtask

   task automatic test_word32();
      string s = "123456789";
      logic [31:0] r;
      fb.delete();
      for (int i = 0; i < 9; i++) fb.push_back(s[i]);
      send_frame(2, 9, 0, 0);
      checks++;
      if (done_s[2] !== 1'b1) begin errors++; $display("FAIL w32_done got %b expected 1", done_s[2]); end
      checks++;
      if (fcs_s[2] !== 32'hCBF43926) begin errors++; $display("FAIL w32_fcs got %h expected cbf43926", fcs_s[2]); end
      fb.delete();
      for (int i = 0; i < 8; i++) fb.push_back(8'h41 + 8'(i));
      r = ref_crc(0, 8);
      send_frame(2, 8, 0, 1);
      checks++;
      if (done_s[2] !== 1'b1) begin errors++; $display("FAIL w32_empty_done got %b expected 1", done_s[2]); end
      checks++;
      if (fcs_s[2] !== ~r) begin errors++; $display("FAIL w32_empty_fcs got %h expected %h", fcs_s[2], ~r); end
      checks++;
      if (crc_s[2] !== rev32(r)) begin errors++; $display("FAIL w32_empty_crc got %h expected %h", crc_s[2], rev32(r)); end
   endtask

   task automatic test_check64();
      logic [31:0] r;
      fb.delete();
      for (int i = 0; i < 60; i++) fb.push_back(8'($urandom));
      r = ref_crc(0, 60);
      for (int k = 0; k < 4; k++) fb.push_back(~r[8*k +: 8]);
      send_frame(3, 64, 0, 0);
      checks++;
      if (crc_s[3] !== 32'hC704DD7B) begin errors++; $display("FAIL chk_residue got %h expected c704dd7b", crc_s[3]); end
`ifdef IOB_ETH_CRC_CHECK_EN
      checks++;
      if (ok_s[3] !== 1'b1) begin errors++; $display("FAIL chk_ok_good got %b expected 1", ok_s[3]); end
`else
      checks++;
      if (ok_s[3] !== 1'b0) begin errors++; $display("FAIL chk_ok_tied got %b expected 0", ok_s[3]); end
`endif
      fb[17] = fb[17] ^ 8'h10;
      r = ref_crc(0, 64);
      send_frame(3, 64, 0, 0);
      checks++;
      if (crc_s[3] !== rev32(r)) begin errors++; $display("FAIL chk_bad_crc got %h expected %h", crc_s[3], rev32(r)); end
      checks++;
      if (ok_s[3] !== 1'b0) begin errors++; $display("FAIL chk_ok_bad got %b expected 0", ok_s[3]); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e1;
      logic [31:0] e2;
      fb.delete();
      for (int i = 0; i < 12; i++) fb.push_back(8'($urandom));
      e1 = ref_crc(0, 8);
      e2 = ref_crc(8, 4);
      @(negedge clk);
      valid_s[2] = 1'b1; be_s[2] = 8'h0F; last_s[2] = 1'b0;
      data_s[2]  = {32'h0, fb[3], fb[2], fb[1], fb[0]};
      #1;
      checks++;
      if (ready_s[2] !== 1'b1) begin errors++; $display("FAIL b2b_ready_c0 got %b expected 1", ready_s[2]); end
      @(negedge clk);
      last_s[2] = 1'b1;
      data_s[2] = {32'h0, fb[7], fb[6], fb[5], fb[4]};
      #1;
      checks++;
      if (ready_s[2] !== 1'b1) begin errors++; $display("FAIL b2b_ready_c1 got %b expected 1", ready_s[2]); end
      @(negedge clk);
      data_s[2] = {32'h0, fb[11], fb[10], fb[9], fb[8]};
      #1;
      checks++;
      if (ready_s[2] !== 1'b0) begin errors++; $display("FAIL b2b_ready_done got %b expected 0", ready_s[2]); end
      checks++;
      if (done_s[2] !== 1'b1 || fcs_s[2] !== ~e1) begin errors++; $display("FAIL b2b_frame1 got done=%b fcs=%h expected done=1 fcs=%h", done_s[2], fcs_s[2], ~e1); end
      @(negedge clk);
      #1;
      checks++;
      if (ready_s[2] !== 1'b1 || done_s[2] !== 1'b0) begin errors++; $display("FAIL b2b_reaccept got ready=%b done=%b expected ready=1 done=0", ready_s[2], done_s[2]); end
      @(negedge clk);
      valid_s[2] = 1'b0; last_s[2] = 1'b0; be_s[2] = '0;
      #1;
      checks++;
      if (done_s[2] !== 1'b1 || fcs_s[2] !== ~e2) begin errors++; $display("FAIL b2b_frame2 got done=%b fcs=%h expected done=1 fcs=%h", done_s[2], fcs_s[2], ~e2); end
   endtask

   task automatic test_rst_start();
      logic        seen;
      logic [31:0] r;
      fb.delete();
      for (int i = 0; i < 10; i++) fb.push_back(8'($urandom));
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         valid_s[1] = 1'b1; be_s[1] = 8'h03; last_s[1] = 1'b0;
         data_s[1]  = {48'h0, fb[2*b+1], fb[2*b]};
      end
      @(negedge clk);
      valid_s[1] = 1'b0;
      #1;
      checks++;
      if (busy_s[1] !== 1'b1) begin errors++; $display("FAIL rst_busy_before got %b expected 1", busy_s[1]); end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (crc_s[1] !== 32'hFFFFFFFF || fcs_s[1] !== 32'h0) begin errors++; $display("FAIL rst_mid_values got crc=%h fcs=%h expected ffffffff/00000000", crc_s[1], fcs_s[1]); end
      checks++;
      if ({busy_s[1], ready_s[1], done_s[1]} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got busy/ready/done=%b expected 000", {busy_s[1], ready_s[1], done_s[1]}); end
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (done_s[1]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b expected 0", seen); end
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         valid_s[1] = 1'b1; be_s[1] = 8'h03; last_s[1] = 1'b0;
         data_s[1]  = {48'h0, fb[2*b+1], fb[2*b]};
      end
      @(negedge clk);
      data_s[1]  = {48'h0, fb[5], fb[4]};
      start_s[1] = 1'b1;
      #1;
      checks++;
      if (ready_s[1] !== 1'b0) begin errors++; $display("FAIL start_ready got %b expected 0", ready_s[1]); end
      @(negedge clk);
      start_s[1] = 1'b0; valid_s[1] = 1'b0;
      #1;
      checks++;
      if (busy_s[1] !== 1'b0 || crc_s[1] !== 32'hFFFFFFFF) begin errors++; $display("FAIL start_abort got busy=%b crc=%h expected 0/ffffffff", busy_s[1], crc_s[1]); end
      r = ref_crc(0, 10);
      send_frame(1, 10, 0, 0);
      checks++;
      if (done_s[1] !== 1'b1 || fcs_s[1] !== ~r) begin errors++; $display("FAIL start_new_frame got done=%b fcs=%h expected 1/%h", done_s[1], fcs_s[1], ~r); end
   endtask

   task automatic test_random();
      logic [31:0] r;
      for (int w = 0; w < 4; w++) begin
         for (int f = 0; f < 3; f++) begin
            int n = int'($urandom_range(1518, 1));
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            r = ref_crc(0, n);
            send_frame(w, n, 2, 0);
            checks++;
            if (done_s[w] !== 1'b1 || fcs_s[w] !== ~r || crc_s[w] !== rev32(r)) begin
               errors++;
               $display("FAIL rand w=%0d len=%0d got done=%b fcs=%h crc=%h expected 1 %h %h", w, n, done_s[w], fcs_s[w], crc_s[w], ~r, rev32(r));
            end
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      start_s = '0;
      valid_s = '0;
      last_s  = '0;
      for (int w = 0; w < 4; w++) begin
         data_s[w] = '0;
         be_s[w]   = '0;
      end
      test_reset();
      test_byte8();
      test_word32();
      test_check64();
      test_back_to_back();
      test_rst_start();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
